// File: rtl/pipelined_alu_if.sv
// Operand/result handshake bundle for pipelined_alu.
// Ports: in_valid/in_ready/opA/opB/ctrl (operand channel), out_valid/out_ready/result/overflow (result channel).
// slave = ALU side, master = operand source / result sink side.
interface pipelined_alu_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [2:0]       ctrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             overflow;

   modport slave (
      input  in_valid, opA, opB, ctrl, out_ready,
      output in_ready, out_valid, result, overflow
   );

   modport master (
      output in_valid, opA, opB, ctrl, out_ready,
      input  in_ready, out_valid, result, overflow
   );
endinterface

// File: rtl/pipelined_alu.sv
// Registered ALU: AND/ADD/OR/SUB/XOR in one cycle, shift-add MUL in WIDTH cycles, one-entry output register.
// Latency: 1 cycle for logic/add/sub/reserved ops, WIDTH+1 cycles for MUL (fixed, independent of operands).
// Backpressure: in_ready drops while MUL runs or the output register is full and out_ready is low.
// Ports: clk, reset (sync, active-high), alu (pipelined_alu_if.slave: operand and result channels).
// Optional: define ALU_SAT_EN to saturate ADD/SUB on signed overflow and MUL on unsigned overflow.
module pipelined_alu #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   pipelined_alu_if.slave alu
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   mplier;

   logic               out_valid_q;
   logic [WIDTH-1:0]   result_q;
   logic               overflow_q;

   logic               accept;
   logic               load_alu;
   logic               load_mul;
   logic               start_mul;
   logic               mul_step;

   logic               is_sub;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH-1:0]   sum;
   logic               add_ovf;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;
   logic [WIDTH-1:0]   mul_res;
   logic               mul_ovf;

   // Drain-and-accept in the same cycle is allowed when the sink takes the pending result.
   assign alu.in_ready  = (state == IDLE) && (!out_valid_q || alu.out_ready);
   assign accept        = alu.in_valid && alu.in_ready;

   assign alu.out_valid = out_valid_q;
   assign alu.result    = result_q;
   assign alu.overflow  = overflow_q;

   // Single-cycle ops. SUB reuses the adder as A + ~B + 1.
   always_comb begin
      is_sub  = (alu.ctrl == OP_SUB);
      b_eff   = is_sub ? ~alu.opB : alu.opB;
      sum     = alu.opA + b_eff + WIDTH'(is_sub);
      // Signed overflow: effective operands share a sign the sum does not.
      add_ovf = (alu.opA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != alu.opA[WIDTH-1]);
      alu_res = '0;
      alu_ovf = 1'b0;
      case (alu.ctrl)
         OP_AND: alu_res = alu.opA & alu.opB;
         OP_OR:  alu_res = alu.opA | alu.opB;
         OP_XOR: alu_res = alu.opA ^ alu.opB;
         OP_ADD, OP_SUB: begin
            alu_res = sum;
            alu_ovf = add_ovf;
`ifdef ALU_SAT_EN
            // Overflow direction follows the operand sign.
            if (add_ovf) begin
               alu_res = alu.opA[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
         end
         default: begin
            // Reserved codes produce zero; MUL never loads through this path.
         end
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
   assign acc_step = mplier[0] ? (acc + mcand) : acc;
   assign mul_ovf  = |acc_step[2*WIDTH-1:WIDTH];

   always_comb begin
      mul_res = acc_step[WIDTH-1:0];
`ifdef ALU_SAT_EN
      if (mul_ovf) begin
         mul_res = '1;
      end
`endif
   end

   // The final multiply step and the result load share one edge, giving WIDTH BUSY cycles.
   always_comb begin
      state_nxt = state;
      load_alu  = 1'b0;
      load_mul  = 1'b0;
      start_mul = 1'b0;
      mul_step  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (alu.ctrl == OP_MUL) begin
                  start_mul = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  load_alu  = 1'b1;
               end
            end
         end
         BUSY: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               load_mul  = 1'b1;
               state_nxt = IDLE;
            end else begin
               mul_step  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
      end else begin
         if (start_mul) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, alu.opA};
            mplier <= alu.opB;
         end else if (mul_step) begin
            cnt    <= cnt + CNT_W'(1);
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
         end else if (load_mul) begin
            cnt    <= '0;
         end

         // Result register only changes on a load, so it holds steady under backpressure.
         if (load_alu) begin
            result_q   <= alu_res;
            overflow_q <= alu_ovf;
         end else if (load_mul) begin
            result_q   <= mul_res;
            overflow_q <= mul_ovf;
         end

         if (load_alu || load_mul) begin
            out_valid_q <= 1'b1;
         end else if (out_valid_q && alu.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule
